// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with load, saturate and cascade tc.
// Ports: clk, rst (sync, active-high), en, up, load, load_val, sat -> q, tc, wrap, load_err.
module modn_updown_counter #(
    parameter int MODULUS   = 10,
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    generate
        if (MODULUS < 2) begin : g_bad_modulus
            $error("modn_updown_counter: MODULUS must be >= 2");
        end
        if ((2 ** WIDTH) < MODULUS) begin : g_bad_width
            $error("modn_updown_counter: WIDTH too small for MODULUS");
        end
        if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
            $error("modn_updown_counter: RESET_VAL out of range");
        end
    endgenerate

    // MAX always fits in WIDTH bits, so range checks compare against it
    // rather than MODULUS (which may equal 2**WIDTH).
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RVAL = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             err_next;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            if (load_val > MAX) begin
                q_next   = MAX;
                err_next = 1'b1;
            end else begin
                q_next = load_val;
            end
        end else if (en) begin
            if (q > MAX) begin
                // Recover from an unreachable code toward the count direction.
                q_next = up ? ZERO : MAX;
            end else if (up) begin
                if (q == MAX) begin
                    if (!sat) begin
                        q_next    = ZERO;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q + ONE;
                end
            end else begin
                if (q == ZERO) begin
                    if (!sat) begin
                        q_next    = MAX;
                        wrap_next = 1'b1;
                    end
                end else begin
                    q_next = q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q        <= RVAL;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            q        <= q_next;
            wrap     <= wrap_next;
            load_err <= err_next;
        end
    end

    // Independent of sat: a saturated counter at its bound still reports tc.
    assign tc = en & (up ? (q == MAX) : (q == ZERO));

endmodule
